// File: rtl/decode_dispatch_ctrl.sv
// decode_dispatch_ctrl
// 2-wide in-order decode/dispatch scheduler between the fetch queue and the
// backend. It buffers up to two fetched instructions, classifies each one as
// ALU/MUL/MEM/BR and releases them oldest-first when ROB and reservation-station
// credits cover them. The backend always accepts, so credits act as back-pressure.
//
// Optional feature: define DISPATCH_PERF_EN to build the stall counters.
// When it is undefined, both perf outputs are tied to zero.
//
// Ports
//   clk, rst_n          clock; synchronous active-low reset
//   flush               squash the buffered instructions
//   fq_valid/inst/pc    fetch pair {lane1,lane0}; lane0 is the oldest
//   fq_ready            the fetch pair is accepted this cycle
//   rob_free            free ROB entries
//   rs_*_free           free RS slots per class, saturated at 2
//   disp_valid/class/illegal/inst/pc
//                       dispatch lanes {lane1,lane0}; unused lanes drive 0
//   perf_stall_rob/rs   stall-cycle counters
module decode_dispatch_ctrl #(
    parameter int unsigned ROB_IDX_W = 5,
    parameter int unsigned PC_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [1:0]            fq_valid,
    input  logic [63:0]           fq_inst,
    input  logic [2*PC_W-1:0]     fq_pc,
    output logic                  fq_ready,
    input  logic [ROB_IDX_W:0]    rob_free,
    input  logic [1:0]            rs_alu_free,
    input  logic [1:0]            rs_mul_free,
    input  logic [1:0]            rs_mem_free,
    input  logic [1:0]            rs_br_free,
    output logic [1:0]            disp_valid,
    output logic [3:0]            disp_class,
    output logic [1:0]            disp_illegal,
    output logic [63:0]           disp_inst,
    output logic [2*PC_W-1:0]     disp_pc,
    output logic [31:0]           perf_stall_rob,
    output logic [31:0]           perf_stall_rs
);

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

    localparam logic [ROB_IDX_W:0] ROB_ZERO = '0;
    localparam logic [ROB_IDX_W:0] ROB_TWO  = (ROB_IDX_W+1)'(2);

    state_t          r_state;
    logic [31:0]     r_inst0, r_inst1;
    logic [PC_W-1:0] r_pc0, r_pc1;

    // Returns {illegal, class[1:0]}.
    function automatic logic [2:0] classify(input logic [31:0] inst);
        logic [2:0] res;
        unique case (inst[6:0])
            7'b0110111, 7'b0010111, 7'b0010011: res = 3'b000;
            7'b0110011: res = (inst[31:25] == 7'b0000001) ? 3'b001 : 3'b000;
            7'b0000011, 7'b0100011:             res = 3'b010;
            7'b1101111, 7'b1100111, 7'b1100011: res = 3'b011;
            default:                            res = 3'b100;
        endcase
        return res;
    endfunction

    function automatic logic [1:0] free_of(input logic [1:0] cls, input logic [1:0] alu,
                                           input logic [1:0] mul, input logic [1:0] mem,
                                           input logic [1:0] br);
        logic [1:0] res;
        unique case (cls)
            2'd0:    res = alu;
            2'd1:    res = mul;
            2'd2:    res = mem;
            default: res = br;
        endcase
        return res;
    endfunction

    logic [2:0] w_dec0, w_dec1;
    logic [1:0] w_free0, w_free1;
    logic       w_active, w_go0, w_go1, w_empty_after, w_accept;

    assign w_dec0  = classify(r_inst0);
    assign w_dec1  = classify(r_inst1);
    assign w_free0 = free_of(w_dec0[1:0], rs_alu_free, rs_mul_free, rs_mem_free, rs_br_free);
    assign w_free1 = free_of(w_dec1[1:0], rs_alu_free, rs_mul_free, rs_mem_free, rs_br_free);

    assign w_active = rst_n & ~flush;
    assign w_go0    = w_active & (r_state != ST_EMPTY) & (rob_free != ROB_ZERO)
                    & (w_free0 != 2'd0);
    // A second instruction of the same class needs two slots of that class.
    assign w_go1    = w_go0 & (r_state == ST_TWO) & (rob_free >= ROB_TWO)
                    & ((w_dec1[1:0] == w_dec0[1:0]) ? (w_free1 == 2'd2) : (w_free1 != 2'd0));

    always_comb begin
        unique case (r_state)
            ST_EMPTY: w_empty_after = 1'b1;
            ST_ONE:   w_empty_after = w_go0;
            default:  w_empty_after = w_go1;
        endcase
    end

    assign fq_ready = w_active & w_empty_after;
    assign w_accept = fq_ready & fq_valid[0];

    assign disp_valid   = {w_go1, w_go0};
    assign disp_class   = {w_go1 ? w_dec1[1:0] : 2'd0, w_go0 ? w_dec0[1:0] : 2'd0};
    assign disp_illegal = {w_go1 & w_dec1[2], w_go0 & w_dec0[2]};
    assign disp_inst    = {w_go1 ? r_inst1 : 32'h0, w_go0 ? r_inst0 : 32'h0};
    assign disp_pc      = {w_go1 ? r_pc1 : {PC_W{1'b0}}, w_go0 ? r_pc0 : {PC_W{1'b0}}};

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_state <= ST_EMPTY;
        end else if (fq_ready) begin
            // Buffer drains this cycle, so a new pair (or nothing) replaces it.
            if (w_accept) begin
                r_state <= fq_valid[1] ? ST_TWO : ST_ONE;
                r_inst0 <= fq_inst[31:0];
                r_inst1 <= fq_inst[63:32];
                r_pc0   <= fq_pc[PC_W-1:0];
                r_pc1   <= fq_pc[2*PC_W-1:PC_W];
            end else begin
                r_state <= ST_EMPTY;
            end
        end else if (r_state == ST_TWO && w_go0) begin
            r_state <= ST_ONE;
            r_inst0 <= r_inst1;
            r_pc0   <= r_pc1;
        end
    end

`ifdef DISPATCH_PERF_EN
    logic [31:0] r_stall_rob, r_stall_rs;
    logic        w_blocked;

    assign w_blocked = w_active & (r_state != ST_EMPTY) & ~w_go0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_rob <= 32'h0;
            r_stall_rs  <= 32'h0;
        end else if (w_blocked) begin
            if (rob_free == ROB_ZERO) begin
                if (r_stall_rob != 32'hFFFF_FFFF) r_stall_rob <= r_stall_rob + 32'd1;
            end else if (r_stall_rs != 32'hFFFF_FFFF) begin
                // rob_free is non-zero, so the class credit is what blocked lane0.
                r_stall_rs <= r_stall_rs + 32'd1;
            end
        end
    end

    assign perf_stall_rob = r_stall_rob;
    assign perf_stall_rs  = r_stall_rs;
`else
    assign perf_stall_rob = 32'h0;
    assign perf_stall_rs  = 32'h0;
`endif

endmodule
